// File: rtl/alu8_pkg.sv
// Shared opcode, mode and width constants for the 8-bit ALU execute stage.
package alu8_pkg;

  localparam int W = 8;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_INC = 4'h2;
  localparam logic [3:0] OP_DEC = 4'h3;
  localparam logic [3:0] OP_ADC = 4'h4;
  localparam logic [3:0] OP_SBB = 4'h5;
  localparam logic [3:0] OP_CMP = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_XOR = 4'hA;
  localparam logic [3:0] OP_SHL = 4'hB;
  localparam logic [3:0] OP_SHR = 4'hC;
  localparam logic [3:0] OP_ASR = 4'hD;
  localparam logic [3:0] OP_ROL = 4'hE;
  localparam logic [3:0] OP_ROR = 4'hF;

endpackage

// File: rtl/alu8_shifter.sv
// Combinational shift/rotate unit; o_co is the bit shifted or rotated out.
module alu8_shifter
  import alu8_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [3:0]   i_op,
  output logic [W-1:0] o_res,
  output logic         o_co
);

  always_comb begin
    o_res = i_a;
    o_co  = 1'b0;
    case (i_op)
      OP_SHL: begin
        o_res = {i_a[W-2:0], 1'b0};
        o_co  = i_a[W-1];
      end
      OP_SHR: begin
        o_res = {1'b0, i_a[W-1:1]};
        o_co  = i_a[0];
      end
      OP_ASR: begin
        o_res = {i_a[W-1], i_a[W-1:1]};
        o_co  = i_a[0];
      end
      OP_ROL: begin
        o_res = {i_a[W-2:0], i_a[W-1]};
        o_co  = i_a[W-1];
      end
      OP_ROR: begin
        o_res = {i_a[0], i_a[W-1:1]};
        o_co  = i_a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu8_core.sv
// 8-bit registered ALU execute stage, one-cycle latency.
// Define ALU8_PARITY_EN to add the registered parity output p.
module alu8_core
  import alu8_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         mode,
  input  logic [3:0]   op,
  output logic [W-1:0] f,
  output logic         v,
  output logic         z,
  output logic         n,
  output logic         c
`ifdef ALU8_PARITY_EN
  ,
  output logic         p
`endif
);

  logic [W-1:0] w_x;
  logic [W-1:0] w_sh;
  logic [W-1:0] w_r;
  logic [W:0]   w_sum;
  logic         w_sub;
  logic         w_ci;
  logic         w_sh_c;
  logic         w_c;
  logic         w_v;
  logic         w_arith;
  logic         w_logic;

  logic [W-1:0] r_f;
  logic         r_v;
  logic         r_z;
  logic         r_n;
  logic         r_c;

  assign w_arith = (mode == MODE_ARITH) && (op <= OP_CMP);
  assign w_logic = (mode == MODE_LOGIC) && (op >= OP_OR);

  alu8_shifter u_sh (
    .i_a   (a),
    .i_op  (op),
    .o_res (w_sh),
    .o_co  (w_sh_c)
  );

  // INC/DEC reuse the adder with a constant-one second operand
  always_comb begin
    w_x   = b;
    w_sub = 1'b0;
    w_ci  = 1'b0;
    case (op)
      OP_SUB,
      OP_CMP: w_sub = 1'b1;
      OP_INC: w_x = 8'd1;
      OP_DEC: begin
        w_x   = 8'd1;
        w_sub = 1'b1;
      end
      OP_ADC: w_ci = cin;
      OP_SBB: begin
        w_sub = 1'b1;
        w_ci  = cin;
      end
      default: ;
    endcase
  end

  assign w_sum = w_sub
    ? {1'b0, a} - {1'b0, w_x} - {{W{1'b0}}, w_ci}
    : {1'b0, a} + {1'b0, w_x} + {{W{1'b0}}, w_ci};

  always_comb begin
    w_r = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    unique case (1'b1)
      w_arith: begin
        w_r = w_sum[W-1:0];
        w_c = w_sum[W];
        w_v = (a[W-1] ^ w_r[W-1])
            & (w_sub ^ ~(a[W-1] ^ w_x[W-1]));
      end
      w_logic: begin
        case (op)
          OP_OR:  w_r = a | b;
          OP_AND: w_r = a & b;
          OP_NOT: w_r = ~a;
          OP_XOR: w_r = a ^ b;
          default: begin
            w_r = w_sh;
            w_c = w_sh_c;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f <= '0;
      r_v <= 1'b0;
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_c <= 1'b0;
    end else begin
      r_f <= w_r;
      r_v <= w_v;
      r_z <= (w_r == '0);
      r_n <= w_r[W-1];
      r_c <= w_c;
    end
  end

  assign f = r_f;
  assign v = r_v;
  assign z = r_z;
  assign n = r_n;
  assign c = r_c;

`ifdef ALU8_PARITY_EN
  logic r_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_p <= 1'b0;
    else        r_p <= ^w_r;
  end

  assign p = r_p;
`endif

endmodule

// File: tb/tb_alu8_core.sv
// Bench for alu8_core: directed cases plus random ops vs an integer model.
// Define ALU8_PARITY_EN to also check p.
module tb_alu8_core;

  typedef struct packed {
    logic [7:0] f;
    logic       v;
    logic       z;
    logic       n;
    logic       c;
    logic       p;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       mode;
  logic [3:0] op;
  logic [7:0] f;
  logic       v;
  logic       z;
  logic       n;
  logic       c;
`ifdef ALU8_PARITY_EN
  logic       p;
`endif

  int   n_tests;
  int   n_fail;
  exp_t prev;

  alu8_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .mode  (mode),
    .op    (op),
    .f     (f),
    .v     (v),
    .z     (z),
    .n     (n),
    .c     (c)
`ifdef ALU8_PARITY_EN
    ,
    .p     (p)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic exp_t model(input int ia, input int ib,
                                 input int ic, input bit md,
                                 input int iop);
    exp_t e;
    int   r;
    int   s;
    bit   cc;
    bit   vv;
    bit   legal;
    r  = 0;
    cc = 0;
    vv = 0;
    legal = md ? (iop >= 7) : (iop <= 6);
    if (legal) begin
      case (iop)
        0: begin
          r = ia + ib; cc = r > 255;
          s = sx(ia) + sx(ib); vv = s > 127 || s < -128;
        end
        1, 6: begin
          r = ia - ib; cc = ia < ib;
          s = sx(ia) - sx(ib); vv = s > 127 || s < -128;
        end
        2: begin r = ia + 1; cc = ia == 255; vv = ia == 127; end
        3: begin r = ia - 1; cc = ia == 0; vv = ia == 128; end
        4: begin
          r = ia + ib + ic; cc = r > 255;
          s = sx(ia) + sx(ib) + ic; vv = s > 127 || s < -128;
        end
        5: begin
          r = ia - ib - ic; cc = ia < ib + ic;
          s = sx(ia) - sx(ib) - ic; vv = s > 127 || s < -128;
        end
        7:  r = ia | ib;
        8:  r = ia & ib;
        9:  r = 255 - ia;
        10: r = ia ^ ib;
        11: begin r = ia * 2; cc = ia >= 128; end
        12: begin r = ia / 2; cc = ia % 2; end
        13: begin r = sx(ia) >>> 1; cc = ia % 2; end
        14: begin r = ia * 2 + ia / 128; cc = ia >= 128; end
        default: begin r = ia / 2 + (ia % 2) * 128; cc = ia % 2; end
      endcase
    end
    r   = r & 255;
    e.f = r[7:0];
    e.v = vv;
    e.c = cc;
    e.z = (r == 0);
    e.n = r >= 128;
    e.p = ^e.f;
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, "_f"}, {24'd0, f}, {24'd0, e.f});
    chk({tag, "_vznc"}, {28'd0, v, z, n, c},
        {28'd0, e.v, e.z, e.n, e.c});
`ifdef ALU8_PARITY_EN
    chk({tag, "_p"}, {31'd0, p}, {31'd0, e.p});
`endif
  endtask

  // Drive on negedge, confirm the old result still holds, then check
  // the new result just after the following rising edge.
  task automatic do_op(input string tag, input int ia, input int ib,
                       input int ic, input bit md, input int iop);
    exp_t e;
    @(negedge clk);
    a    = ia[7:0];
    b    = ib[7:0];
    cin  = ic[0];
    mode = md;
    op   = iop[3:0];
    #1;
    chk({tag, "_hold"}, {24'd0, f}, {24'd0, prev.f});
    @(posedge clk);
    #1;
    e = model(ia, ib, ic, md, iop);
    check_out(tag, e);
    prev = e;
  endtask

  initial begin
    exp_t zero;
    n_tests = 0;
    n_fail  = 0;
    zero    = '0;
    prev    = '0;
    rst_n   = 1'b0;
    a       = 8'd0;
    b       = 8'd0;
    cin     = 1'b0;
    mode    = 1'b0;
    op      = 4'd0;

    #1;
    check_out("reset", zero);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_out("reset_rel", zero);

    do_op("add", 22, 10, 0, 0, 0);
    do_op("sub", 32, 10, 0, 0, 1);
    do_op("inc", 23, 0, 1, 0, 2);
    do_op("dec", 32, 0, 0, 0, 3);
    do_op("adc", 22, 10, 1, 0, 4);
    do_op("sbb", 2, 10, 1, 0, 5);
    do_op("cmp", 2, 2, 0, 0, 6);
    do_op("add_ovf", 8'h7F, 1, 0, 0, 0);
    do_op("inc_ff", 8'hFF, 0, 0, 0, 2);
    do_op("dec_00", 0, 0, 0, 0, 3);
    do_op("or", 22, 11, 0, 1, 7);
    do_op("and", 20, 10, 0, 1, 8);
    do_op("not", 2, 99, 1, 1, 9);
    do_op("xor", 2, 10, 0, 1, 10);
    do_op("shl", 8, 0, 0, 1, 11);
    do_op("shr", 8, 0, 0, 1, 12);
    do_op("asr", 55, 0, 0, 1, 13);
    do_op("asr_80", 8'h80, 0, 0, 1, 13);
    do_op("rol", 22, 0, 0, 1, 14);
    do_op("ror", 88, 0, 0, 1, 15);
    do_op("ror_01", 1, 0, 0, 1, 15);
    do_op("ill_m1", 8'h55, 8'h33, 1, 1, 0);
    do_op("ill_m0", 8'h80, 8'h01, 1, 0, 11);
    do_op("sbb_ovf", 8'h7F, 8'h80, 1, 0, 5);

    // Mid-cycle async reset after a non-zero result
    do_op("pre_rst", 8'h40, 8'h01, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", zero);
    @(posedge clk);
    #1;
    check_out("rst_hold", zero);
    rst_n = 1'b1;
    prev  = zero;
    do_op("post_rst", 22, 10, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      do_op("rand", int'($urandom_range(255)), int'($urandom_range(255)),
            int'($urandom_range(1)), bit'($urandom_range(1)),
            int'($urandom_range(15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
